// File: rtl/disp_fifo.sv
// disp_fifo: pixel buffer between the AXI read controller and the display
// timing stage. It stores R-channel beats and returns one RGB888 pixel one
// cycle after each request. FIFOREADY is raised while a whole burst still
// fits. Sticky flags record dropped beats (overflow) and starved requests
// (underflow).
module disp_fifo #(
    parameter int DEPTH     = 512,
    parameter int BURST_LEN = 32,
    parameter int AW        = 9
) (
    input  logic          ACLK,
    input  logic          ARST,
    input  logic          CLR,
    input  logic [31:0]   WDATA,
    input  logic          WVALID,
    output logic          FIFOREADY,
    input  logic          PIXRD,
    output logic [23:0]   PIXDATA,
    output logic          PIXVLD,
    output logic          EMPTY,
    output logic [AW:0]   LEVEL,
    output logic          OVERFLOW,
    output logic          UNDERFLOW
);

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] LP_BURST = (AW+1)'(BURST_LEN);

    // Only the pixel bytes are stored. The top byte of each beat carries no
    // pixel data.
    logic [23:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_level;
    logic [23:0]   r_pixdata;
    logic          r_pixvld;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_wr;
    logic          w_rd;
    logic [AW:0]   w_free;
    logic          w_unused;

    // Full and empty are judged on the level at the start of the cycle, so
    // a same-cycle read never makes room and a same-cycle write never feeds
    // a same-cycle read.
    assign w_full   = (r_level == LP_DEPTH);
    assign w_empty  = (r_level == '0);
    assign w_wr     = WVALID & ~w_full & ~CLR;
    assign w_rd     = PIXRD & ~w_empty & ~CLR;
    assign w_free   = LP_DEPTH - r_level;
    assign w_unused = ^WDATA[31:24];

    assign FIFOREADY = (w_free >= LP_BURST);
    assign EMPTY     = w_empty;
    assign LEVEL     = r_level;
    assign PIXDATA   = r_pixdata;
    assign PIXVLD    = r_pixvld;
    assign OVERFLOW  = r_overflow;
    assign UNDERFLOW = r_underflow;

    // Storage array: accepts a beat at the write pointer on each write.
    // NOTE: the array has no reset. Nothing is read from it until a write
    // has filled that slot, and a reset would block mapping onto block RAM.
    always_ff @(posedge ACLK) begin
        if (w_wr) begin
            r_mem[r_wp] <= WDATA[23:0];
        end
    end

    // Pointers, level, pixel output register and sticky flags.
    // NOTE: all state uses non-blocking assignments. Every register then
    // samples values from before the edge, which the full/empty rules
    // depend on.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_level     <= '0;
            r_pixdata   <= '0;
            r_pixvld    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (CLR) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_level     <= '0;
            r_pixdata   <= '0;
            r_pixvld    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + 1'b1;
            end
            if (WVALID && w_full) begin
                r_overflow <= 1'b1;
            end

            if (w_rd) begin
                r_pixdata <= r_mem[r_rp];
                r_pixvld  <= 1'b1;
                r_rp      <= r_rp + 1'b1;
            end else if (PIXRD) begin
                // A starved request returns black and is flagged.
                r_pixdata   <= '0;
                r_pixvld    <= 1'b0;
                r_underflow <= 1'b1;
            end else begin
                r_pixvld <= 1'b0;
            end

            if (w_wr && !w_rd) begin
                r_level <= r_level + 1'b1;
            end else if (w_rd && !w_wr) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule

// File: doc/disp_fifo.md
Name: disp_fifo

Overview:
- Pixel buffer between the AXI read controller (upstream) and the display timing/output stage (downstream).
- Stores 32-bit read-data beats from the AXI R channel in a synchronous FIFO.
- Raises FIFOREADY while room remains for one more full burst, so the upstream controller can issue its next read.
- Delivers one RGB888 pixel per read request with 1-cycle latency, and flags overflow/underflow.

Parameters:
- DEPTH, 512, FIFO depth in 32-bit words; power of two, minimum 64.
- BURST_LEN, 32, words per AXI burst (0x80 bytes / 4); must be less than or equal to DEPTH.
- AW, 9, pointer width; equals log2(DEPTH).

Ports:
- ACLK  in  1  clock (all logic on rising edge)
- ARST  in  1  reset, asynchronous, active-high
- CLR  in  1  synchronous flush at frame start; one-cycle pulse
- WDATA  in  32  AXI RDATA beat; pixel in [23:0] as R[23:16] G[15:8] B[7:0]; [31:24] ignored
- WVALID  in  1  beat valid (RVALID & RREADY of the AXI port)
- FIFOREADY  out  1  free space is at least BURST_LEN
- PIXRD  in  1  pixel request from the display timing stage
- PIXDATA  out  24  pixel returned 1 cycle after PIXRD
- PIXVLD  out  1  PIXDATA holds real FIFO data
- EMPTY  out  1  level == 0
- LEVEL  out  AW+1  current word count, 0..DEPTH
- OVERFLOW  out  1  sticky: a beat was dropped
- UNDERFLOW  out  1  sticky: PIXRD was asserted while empty

Behaviour:
- Reset (ARST high, asynchronous): write/read pointers = 0, LEVEL = 0, PIXDATA = 0, PIXVLD = 0, OVERFLOW = 0, UNDERFLOW = 0. Outputs then read FIFOREADY = 1 and EMPTY = 1.
- Storage: DEPTH x 32 register/BRAM array, pointers AW bits wide, wrapping naturally from DEPTH-1 to 0. Memory contents are not reset.
- Write: when WVALID=1 and LEVEL<DEPTH, in that cycle:
  - mem[wp] <= WDATA
  - wp <= wp+1
- Write while full: when WVALID=1 and LEVEL==DEPTH, the beat is dropped and OVERFLOW <= 1. A same-cycle read does not make room; full is judged on the pre-cycle LEVEL.
- Read: when PIXRD=1 and LEVEL>0, then on the next edge:
  - PIXDATA <= mem[rp][23:0]
  - PIXVLD <= 1
  - rp <= rp+1
- Read while empty: when PIXRD=1 and LEVEL==0, then on the next edge:
  - PIXDATA <= 24'h000000 (black)
  - PIXVLD <= 0
  - UNDERFLOW <= 1
  - There is no write-to-read bypass, even if a write occurs in the same cycle.
- No request: when PIXRD=0, PIXVLD <= 0 and PIXDATA holds its last value.
- LEVEL update per cycle: +1 on an accepted write only, -1 on an accepted read only, unchanged on both or neither. It never exceeds DEPTH or goes below 0.
- FIFOREADY = ((DEPTH - LEVEL) >= BURST_LEN). Combinational from registered LEVEL, so it has no extra latency. The upstream controller samples it only after RLAST, which guarantees any burst it issues fits.
- EMPTY = (LEVEL == 0), combinational.
- CLR (synchronous, highest priority after ARST):
  - pointers, LEVEL, PIXVLD, OVERFLOW, UNDERFLOW <= 0
  - PIXDATA <= 0
  - any WVALID or PIXRD in the same cycle is ignored
- Sticky flags clear only on ARST or CLR.
- Reset mid-operation: ARST asserted during a burst returns every register to its reset value immediately. Beats arriving while ARST is high are discarded.

Test Plan (DEPTH=64, BURST_LEN=32):
1. After reset: LEVEL=0, EMPTY=1, FIFOREADY=1, PIXVLD=0, flags=0. Write 32 beats 0x00000000..0x0000001F, then LEVEL=32 and FIFOREADY=1. Write 1 more beat, then LEVEL=33 and FIFOREADY=0.
2. Fill 64 beats, then drive WVALID with 0xDEADBEEF: OVERFLOW=1, LEVEL stays 64. Read 64 pixels: PIXDATA returns in order 0x000000..0x00003F, each one cycle after its PIXRD, and 0xADBEEF never appears.
3. Continuous write and read across wrap: 200 beats with WDATA=0xFF000000|i, PIXRD held high once LEVEL>=4. The output sequence i[23:0] must match with no gaps, and LEVEL must stay constant in both-active cycles.
4. PIXRD on an empty FIFO: next cycle PIXDATA=0x000000, PIXVLD=0, UNDERFLOW=1. A same-cycle write of 0x00123456 gives LEVEL=1, and the following PIXRD returns 0x123456.
5. With LEVEL=40 and OVERFLOW=1, pulse CLR together with WVALID and PIXRD: next cycle LEVEL=0, EMPTY=1, FIFOREADY=1, flags=0, PIXVLD=0.
6. Assert ARST asynchronously mid-burst (LEVEL=10, between clock edges): outputs reach reset values before the next edge. After release, the first written word is the first word read.
